// File: rtl/pwm_multi_engine.sv
// Multi-channel PWM generator with a shadow/active configuration pair per channel.
// New settings reach the output at a period wrap, or on the next clock while a channel is idle.
module pwm_multi_engine #(
  parameter int NUM_CH   = 8,
  parameter int CH_W     = 3,
  parameter int CNT_W    = 32,
  parameter int DEF_HIGH = 1000,
  parameter int DEF_LOW  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_enable,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sync_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_invert,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] period_done
);

  typedef struct packed {
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] low;
    logic [CNT_W-1:0] phase;
    logic             invert;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{high: CNT_W'(DEF_HIGH), low: CNT_W'(DEF_LOW),
                               phase: '0, invert: 1'b0};

  cfg_t              r_shadow [NUM_CH];
  cfg_t              r_active [NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic [CNT_W:0]    r_cnt    [NUM_CH];
  logic [NUM_CH-1:0] r_out;
  logic [NUM_CH-1:0] r_done;

  cfg_t              w_cfg_in;
  logic              w_pend_sel;
  logic              w_ch_ok;
  logic              w_wr;
  logic [NUM_CH-1:0] w_run;
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_copy;
  logic [NUM_CH-1:0] w_wr_ch;
  logic [NUM_CH-1:0] w_level;
  logic [CNT_W:0]    w_period [NUM_CH];
  logic [CNT_W:0]    w_start  [NUM_CH];

  assign w_cfg_in = '{high: cfg_high, low: cfg_low, phase: cfg_phase, invert: cfg_invert};

  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so no latch can form.
    w_pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (int'(cfg_ch) == i) w_pend_sel = r_pending[i];
    w_ch_ok   = int'(cfg_ch) < NUM_CH;
    cfg_ready = w_ch_ok && !w_pend_sel;
    w_wr      = cfg_valid && cfg_ready;

    for (int i = 0; i < NUM_CH; i++) begin
      w_run[i]    = pwm_enable & ch_enable[i];
      w_period[i] = {1'b0, r_active[i].high} + {1'b0, r_active[i].low};
      w_start[i]  = ({1'b0, r_active[i].phase} < w_period[i]) ? {1'b0, r_active[i].phase} : '0;
      // A sync_start load is a restart, not a wrap: it neither pulses nor swaps configuration.
      w_wrap[i]   = w_run[i] && !sync_start && (w_period[i] != '0) &&
                    (r_cnt[i] >= w_period[i] - (CNT_W+1)'(1));
      w_copy[i]   = r_pending[i] && (!w_run[i] || w_wrap[i]);
      w_wr_ch[i]  = w_wr && (int'(cfg_ch) == i);
      w_level[i]  = (w_run[i] && (w_period[i] != '0))
                  ? ((r_cnt[i] < {1'b0, r_active[i].high}) ^ r_active[i].invert)
                  : r_active[i].invert;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-channel configuration arrays are plain flops, not RAM, so they are reset.
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= DEF_CFG;
        r_active[i] <= DEF_CFG;
        r_cnt[i]    <= '0;
      end
      r_pending <= '0;
      r_out     <= '0;
      r_done    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_ch[i]) r_shadow[i] <= w_cfg_in;
        if (w_copy[i])  r_active[i] <= r_shadow[i];
        // Idle channels track their start value so the first running cycle already sits on it.
        if (!w_run[i] || sync_start)                  r_cnt[i] <= w_start[i];
        else if (w_wrap[i] || (w_period[i] == '0))    r_cnt[i] <= '0;
        else                                          r_cnt[i] <= r_cnt[i] + (CNT_W+1)'(1);
      end
      // A write never lands on a pending channel (cfg_ready is low), so set and clear are exclusive.
      r_pending <= w_wr_ch | (r_pending & ~w_copy);
      r_out     <= w_level;
      r_done    <= w_wrap;
    end
  end

  assign pwm_out     = r_out;
  assign period_done = r_done;

endmodule

// File: tb/tb_pwm_multi_engine.sv
// Bench for pwm_multi_engine: table-driven pattern vectors, hand-written corner sequences,
// and randomized traffic, all checked every cycle against a behavioural channel model.
module tb_pwm_multi_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_enable;
  logic [7:0]  ch_enable;
  logic        sync_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_ready4;
  logic [2:0]  cfg_ch;
  logic [31:0] cfg_high;
  logic [31:0] cfg_low;
  logic [31:0] cfg_phase;
  logic        cfg_invert;
  logic [7:0]  pwm_out;
  logic [7:0]  period_done;
  logic [3:0]  pwm_out4;
  logic [3:0]  period_done4;

  always #5 clk = ~clk;

  pwm_multi_engine dut (
    .clk(clk), .rst_n(rst_n), .pwm_enable(pwm_enable), .ch_enable(ch_enable),
    .sync_start(sync_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_phase(cfg_phase), .cfg_invert(cfg_invert),
    .pwm_out(pwm_out), .period_done(period_done)
  );

  // Four-channel build sharing all inputs: its channels must track channels 0..3 exactly.
  pwm_multi_engine #(.NUM_CH(4), .CH_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .pwm_enable(pwm_enable), .ch_enable(ch_enable[3:0]),
    .sync_start(sync_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4), .cfg_ch(cfg_ch),
    .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_phase(cfg_phase), .cfg_invert(cfg_invert),
    .pwm_out(pwm_out4), .period_done(period_done4)
  );

  typedef struct { longint h; longint l; longint ph; bit inv; } mcfg_t;
  typedef struct { int ch; int h; int l; int ph; bit inv; logic [7:0] eo; logic [7:0] ed; } vec_t;

  mcfg_t      m_act  [8];
  mcfg_t      m_sh   [8];
  bit         m_pend [8];
  longint     m_pos  [8];
  logic [7:0] m_out;
  logic [7:0] m_done;
  vec_t       tbl    [8];
  logic [7:0] col_out;
  logic [7:0] col_done;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint m_period(int i);
    return m_act[i].h + m_act[i].l;
  endfunction

  function automatic longint m_startpos(int i);
    return (m_act[i].ph < m_period(i)) ? m_act[i].ph : 64'sd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i]  = '{1000, 1000, 0, 1'b0};
      m_sh[i]   = m_act[i];
      m_pend[i] = 1'b0;
      m_pos[i]  = 0;
    end
    m_out  = '0;
    m_done = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit     wr;
    bit     run;
    bit     wrap;
    longint per;
    longint nxt;
    wr = cfg_valid && !m_pend[cfg_ch];
    for (int i = 0; i < 8; i++) begin
      run  = pwm_enable && ch_enable[i];
      per  = m_period(i);
      m_out[i] = (run && per > 0) ? ((m_pos[i] < m_act[i].h) ^ m_act[i].inv) : m_act[i].inv;
      wrap = run && !sync_start && per > 0 && (m_pos[i] >= per - 1);
      m_done[i] = wrap;
      if (!run || sync_start) nxt = m_startpos(i);
      else if (per == 0 || wrap) nxt = 0;
      else nxt = m_pos[i] + 1;
      if (m_pend[i] && (!run || wrap)) begin
        m_act[i]  = m_sh[i];
        m_pend[i] = 1'b0;
      end
      if (wr && int'(cfg_ch) == i) begin
        m_sh[i]   = '{longint'(cfg_high), longint'(cfg_low), longint'(cfg_phase), cfg_invert};
        m_pend[i] = 1'b1;
      end
      m_pos[i] = nxt;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("cfg_ready", 64'(cfg_ready), 64'(!m_pend[cfg_ch]));
    check("cfg_ready4", 64'(cfg_ready4), 64'((cfg_ch < 4) && !m_pend[cfg_ch]));
    model_step();
    @(posedge clk);
    #1;
    check("pwm_out", 64'(pwm_out), 64'(m_out));
    check("period_done", 64'(period_done), 64'(m_done));
    check("pwm_out4", 64'(pwm_out4), 64'(m_out[3:0]));
    check("period_done4", 64'(period_done4), 64'(m_done[3:0]));
  endtask

  task automatic collect(input int ch);
    col_out  = '0;
    col_done = '0;
    for (int j = 0; j < 8; j++) begin
      step();
      col_out  = {col_out[6:0], pwm_out[ch]};
      col_done = {col_done[6:0], period_done[ch]};
    end
  endtask

  task automatic write_cfg(input int ch, input int h, input int l, input int ph, input bit inv);
    cfg_ch     = 3'(ch);
    cfg_high   = 32'(h);
    cfg_low    = 32'(l);
    cfg_phase  = 32'(ph);
    cfg_invert = inv;
    cfg_valid  = 1'b1;
    step();
    cfg_valid  = 1'b0;
  endtask

  // Channel 0 at defaults straight out of reset: 1000 high, 1000 low, wrap every 2000.
  task automatic check_defaults(input string tag);
    int fall = 0;
    int rise = 0;
    int d1   = 0;
    int d2   = 0;
    int nd   = 0;
    bit prev = 1'b1;
    for (int j = 1; j <= 4000; j++) begin
      step();
      if (prev && !pwm_out[0] && fall == 0) fall = j;
      if (!prev && pwm_out[0] && rise == 0) rise = j;
      prev = pwm_out[0];
      if (period_done[0]) begin
        nd++;
        if (d1 == 0) d1 = j;
        else if (d2 == 0) d2 = j;
      end
    end
    check({tag, "_fall"}, 64'(fall), 64'(1001));
    check({tag, "_rise"}, 64'(rise), 64'(2001));
    check({tag, "_done1"}, 64'(d1), 64'(2000));
    check({tag, "_done2"}, 64'(d2), 64'(4000));
    check({tag, "_ndone"}, 64'(nd), 64'(2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int waited;
    int early;
    bit seen;

    tbl[0] = '{4, 1, 3, 0, 1'b1, 8'b01110111, 8'b00010001};
    tbl[1] = '{0, 0, 4, 0, 1'b0, 8'b00000000, 8'b00010001};
    tbl[2] = '{5, 3, 0, 0, 1'b0, 8'b11111111, 8'b00100100};
    tbl[3] = '{6, 0, 0, 0, 1'b0, 8'b00000000, 8'b00000000};
    tbl[4] = '{7, 0, 0, 3, 1'b1, 8'b11111111, 8'b00000000};
    tbl[5] = '{2, 4, 4, 9, 1'b0, 8'b11110000, 8'b00000001};
    tbl[6] = '{1, 4, 4, 5, 1'b0, 8'b00011110, 8'b00100000};
    tbl[7] = '{3, 2, 1, 1, 1'b0, 8'b10110110, 8'b01001001};

    rst_n      = 1'b0;
    pwm_enable = 1'b1;
    ch_enable  = 8'hFF;
    sync_start = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_high   = '0;
    cfg_low    = '0;
    cfg_phase  = '0;
    cfg_invert = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm_out", 64'(pwm_out), 64'(0));
    check("rst_done", 64'(period_done), 64'(0));
    check("rst_ready", 64'(cfg_ready), 64'(1));
    check("rst_pwm_out4", 64'(pwm_out4), 64'(0));
    rst_n = 1'b1;
    check_defaults("def");

    // Mid-period reconfiguration of a running channel waits for its wrap.
    repeat (300) step();
    write_cfg(2, 3, 5, 0, 1'b0);
    check("upd_ready_low", 64'(cfg_ready), 64'(0));
    waited = 0;
    early  = 0;
    seen   = 1'b0;
    for (int k = 0; k < 2100 && !seen; k++) begin
      step();
      waited++;
      if (period_done[2]) seen = 1'b1;
      else if (cfg_ready) early++;
    end
    check("upd_wrap_seen", 64'(seen), 64'(1));
    check("upd_wait", 64'(waited), 64'(1699));
    check("upd_early_ready", 64'(early), 64'(0));
    check("upd_ready_high", 64'(cfg_ready), 64'(1));
    collect(2);
    check("upd_out", 64'(col_out), 64'(8'b11100000));
    check("upd_done", 64'(col_done), 64'(8'b00000001));

    // Asynchronous reset mid-period with a write pending.
    write_cfg(0, 7, 9, 0, 1'b0);
    repeat (5) step();
    check("pend_before_rst", 64'(cfg_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwm_out", 64'(pwm_out), 64'(0));
    check("arst_done", 64'(period_done), 64'(0));
    check("arst_ready", 64'(cfg_ready), 64'(1));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("arst_hold", 64'(pwm_out), 64'(0));
    rst_n = 1'b1;
    check_defaults("rerst");

    // Table: configure an idle channel, check its idle level, enable it, check 8 cycles.
    for (int r = 0; r < 8; r++) begin
      ch_enable[tbl[r].ch] = 1'b0;
      step();
      write_cfg(tbl[r].ch, tbl[r].h, tbl[r].l, tbl[r].ph, tbl[r].inv);
      step();
      step();
      check($sformatf("tbl%0d_idle", r), 64'(pwm_out[tbl[r].ch]), 64'(tbl[r].inv));
      ch_enable[tbl[r].ch] = 1'b1;
      collect(tbl[r].ch);
      check($sformatf("tbl%0d_out", r), 64'(col_out), 64'(tbl[r].eo));
      check($sformatf("tbl%0d_done", r), 64'(col_done), 64'(tbl[r].ed));
    end

    // sync_start aligns two channels started at different times; ch1 is due to wrap on it.
    ch_enable[1] = 1'b0;
    ch_enable[3] = 1'b0;
    step();
    write_cfg(1, 2, 2, 0, 1'b0);
    write_cfg(3, 2, 2, 2, 1'b0);
    step();
    step();
    ch_enable[1] = 1'b1;
    repeat (3) step();
    ch_enable[3] = 1'b1;
    repeat (4) step();
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    check("sync_no_done", 64'(period_done[1]), 64'(0));
    collect(1);
    check("sync_ch1", 64'(col_out), 64'(8'b11001100));
    repeat (4) step();
    collect(3);
    check("sync_ch3", 64'(col_out), 64'(8'b00110011));

    // Channel select beyond the four-channel build is refused there.
    cfg_ch     = 3'd7;
    cfg_high   = 32'd5;
    cfg_low    = 32'd5;
    cfg_phase  = 32'd0;
    cfg_invert = 1'b1;
    cfg_valid  = 1'b1;
    #1;
    check("ch7_ready4", 64'(cfg_ready4), 64'(0));
    check("ch7_ready8", 64'(cfg_ready), 64'(1));
    step();
    cfg_valid = 1'b0;
    repeat (10) step();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      pwm_enable = ($urandom % 16) != 0;
      if ($urandom % 8 == 0) ch_enable = 8'($urandom);
      sync_start = ($urandom % 32) == 0;
      cfg_valid  = ($urandom % 3) == 0;
      cfg_ch     = 3'($urandom % 8);
      cfg_high   = $urandom % 6;
      cfg_low    = $urandom % 6;
      cfg_phase  = $urandom % 10;
      cfg_invert = 1'($urandom % 2);
      step();
    end
    cfg_valid  = 1'b0;
    sync_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
